vmop_issue: RTL and testbench

Command sequencer that drives the vector mask-logical pipeline (vMOP) from the mask register file. It accepts one mask-logical instruction (vd, vs1, vs2, opSel, vl), reads both source mask registers beat by beat, and streams `{addr, m0, m1, opSel, valid}` beats into vMOP at one beat per cycle. It tracks in-flight beats until vMOP writeback returns, then signals completion, so a following instruction never reads a stale vd.

---
 rtl/vmop_pkg.sv | 26 ++
 rtl/vmop_outstanding_ctr.sv | 38 +++
 rtl/vmop_issue.sv | 138 +++++++++++++
 tb/tb_vmop_issue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmop_pkg.sv
// Shared types and constants for the vMOP command sequencer.
`default_nettype none

package vmop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] ANDN = 3'd0;
  localparam logic [2:0] AND  = 3'd1;
  localparam logic [2:0] OR   = 3'd2;
  localparam logic [2:0] XOR  = 3'd3;
  localparam logic [2:0] ORN  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] XNOR = 3'd7;

  localparam int VMOP_LATENCY = 6;

endpackage

`default_nettype wire

// File: rtl/vmop_outstanding_ctr.sv
// Saturating up/down counter of in-flight vMOP beats with a sticky error flag.
`default_nettype none

module vmop_outstanding_ctr #(
  parameter int MAX_OUT = 16,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count == CW'(MAX_OUT)) err <= 1'b1;
          else                       count <= count + CW'(1);
        end
        2'b01: begin
          // A response with nothing in flight is dropped, not wrapped.
          if (count == '0) err <= 1'b1;
          else             count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vmop_issue.sv
// Sequences one mask-logical instruction: reads vs2/vs1 beat by beat, streams
// beats into vMOP and signals completion once every beat has been written back.
`default_nettype none

module vmop_issue
  import vmop_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int OPSEL_WIDTH   = 3,
  parameter int VLEN          = 512,
  parameter int REG_IDX_WIDTH = 5,
  parameter int MAX_OUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [REG_IDX_WIDTH-1:0] cmd_vd,
  input  logic [REG_IDX_WIDTH-1:0] cmd_vs1,
  input  logic [REG_IDX_WIDTH-1:0] cmd_vs2,
  input  logic [OPSEL_WIDTH-1:0]   cmd_opsel,
  input  logic [$clog2(VLEN):0]    cmd_vl,
  output logic                     rf_rd_en,
  output logic [ADDR_WIDTH-1:0]    rf_rd_addr0,
  output logic [ADDR_WIDTH-1:0]    rf_rd_addr1,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data0,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data1,
  output logic                     mop_valid,
  output logic [ADDR_WIDTH-1:0]    mop_addr,
  output logic [DATA_WIDTH-1:0]    mop_m0,
  output logic [DATA_WIDTH-1:0]    mop_m1,
  output logic [OPSEL_WIDTH-1:0]   mop_opsel,
  input  logic                     resp_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int BEATS = VLEN / DATA_WIDTH;
  localparam int VLW   = $clog2(VLEN) + 1;
  localparam int CW    = $clog2(MAX_OUT + 1);

  state_t                   state, state_n;
  logic [REG_IDX_WIDTH-1:0] vd_q, vs1_q, vs2_q;
  logic [OPSEL_WIDTH-1:0]   opsel_q, opsel_pipe;
  logic [VLW-1:0]           nbeats_q, beat_q;
  logic [VLW-1:0]           vl_clamped, cmd_nbeats;
  logic [ADDR_WIDTH-1:0]    addr_pipe, dest_addr;
  logic                     valid_pipe;
  logic                     accept;
  logic [CW-1:0]            outstanding;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE);
  assign vl_clamped = (cmd_vl > VLW'(VLEN)) ? VLW'(VLEN) : cmd_vl;
  assign cmd_nbeats = (vl_clamped + VLW'(DATA_WIDTH - 1)) / VLW'(DATA_WIDTH);

  assign dest_addr   = ADDR_WIDTH'(vd_q) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(beat_q);
  assign rf_rd_addr0 = rf_rd_en ? ADDR_WIDTH'(vs2_q) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(beat_q) : '0;
  assign rf_rd_addr1 = rf_rd_en ? ADDR_WIDTH'(vs1_q) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(beat_q) : '0;

  // Read data arrives the cycle after the strobe, aligned with the piped beat.
  assign mop_valid = valid_pipe;
  assign mop_addr  = valid_pipe ? addr_pipe   : '0;
  assign mop_opsel = valid_pipe ? opsel_pipe  : '0;
  assign mop_m0    = valid_pipe ? rf_rd_data0 : '0;
  assign mop_m1    = valid_pipe ? rf_rd_data1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      opsel_q    <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      valid_pipe <= 1'b0;
      addr_pipe  <= '0;
      opsel_pipe <= '0;
    end else begin
      state      <= state_n;
      valid_pipe <= rf_rd_en;
      addr_pipe  <= rf_rd_en ? dest_addr : '0;
      opsel_pipe <= rf_rd_en ? opsel_q   : '0;
      if (accept) begin
        vd_q     <= cmd_vd;
        vs1_q    <= cmd_vs1;
        vs2_q    <= cmd_vs2;
        opsel_q  <= cmd_opsel;
        nbeats_q <= cmd_nbeats;
        beat_q   <= '0;
      end else if (state == ISSUE) begin
        beat_q <= beat_q + VLW'(1);
      end
    end
  end

  always_comb begin
    state_n  = state;
    rf_rd_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = (cmd_nbeats == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        rf_rd_en = 1'b1;
        if (beat_q == nbeats_q - VLW'(1)) state_n = DRAIN;
      end
      DRAIN: begin
        if (!valid_pipe && (outstanding == '0)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  vmop_outstanding_ctr #(
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_pipe),
    .dec   (resp_valid),
    .count (outstanding),
    .err   (err)
  );

endmodule

`default_nettype wire

// File: tb/tb_vmop_issue.sv
// Bench for vmop_issue: register-file and fixed-latency vMOP models plus a timing-level reference.
`default_nettype none

module tb_vmop_issue;

  localparam int LAT = 6;

  typedef struct packed {
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [2:0] op;
    logic [9:0] vl;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
  logic [2:0]  cmd_opsel = '0;
  logic [9:0]  cmd_vl = '0;
  logic        rf_rd_en;
  logic [31:0] rf_rd_addr0, rf_rd_addr1;
  logic [63:0] rf_rd_data0, rf_rd_data1;
  logic        mop_valid;
  logic [31:0] mop_addr;
  logic [63:0] mop_m0, mop_m1;
  logic [2:0]  mop_opsel;
  logic        resp_valid;
  logic        busy, done, err;

  logic        resp_en = 1'b1;
  logic        stray = 1'b0;
  logic [LAT-1:0] rpipe;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vmop_issue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
    .cmd_opsel(cmd_opsel), .cmd_vl(cmd_vl),
    .rf_rd_en(rf_rd_en), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .mop_valid(mop_valid), .mop_addr(mop_addr),
    .mop_m0(mop_m0), .mop_m1(mop_m1), .mop_opsel(mop_opsel),
    .resp_valid(resp_valid),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [63:0] rfval(input logic [31:0] a);
    return {(a * 32'h9E3779B1) ^ 32'h13579BDF, a ^ 32'hA5A50F0F};
  endfunction

  // Register file: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    rf_rd_data0 <= rf_rd_en ? rfval(rf_rd_addr0) : {$urandom, $urandom};
    rf_rd_data1 <= rf_rd_en ? rfval(rf_rd_addr1) : {$urandom, $urandom};
  end

  // vMOP: each accepted beat comes back LAT cycles later.
  always @(posedge clk) begin
    if (rst) rpipe <= '0;
    else     rpipe <= {rpipe[LAT-2:0], mop_valid};
  end
  assign resp_valid = (resp_en & rpipe[LAT-1]) | stray;

  task automatic drive(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_vd    = c.vd;
    cmd_vs1   = c.vs1;
    cmd_vs2   = c.vs2;
    cmd_opsel = c.op;
    cmd_vl    = c.vl;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Caller leaves c on the command bus with cmd_valid high; the next edge accepts it.
  task automatic run_cmd(input string tag, input cmd_t c, input bit has_next, input cmd_t n);
    int vlc, nb, dc, k, j;
    logic        e_rd, e_mv;
    logic [31:0] e_a0, e_a1, e_ma;
    logic [63:0] e_m0, e_m1;
    logic [2:0]  e_op;
    vlc = (int'(c.vl) > 512) ? 512 : int'(c.vl);
    nb  = (vlc + 63) / 64;
    dc  = (nb == 0) ? 1 : nb + LAT + 3;
    n_asserts++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: got %b want 1", tag, cmd_ready);
    end
    @(posedge clk); #1;
    if (has_next) drive(n);
    else          cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= dc + 1; cyc++) begin
      @(negedge clk);
      k    = cyc - 1;
      j    = cyc - 2;
      e_rd = (nb > 0) && (cyc <= nb);
      e_a0 = e_rd ? 32'(int'(c.vs2) * 8 + k) : 32'd0;
      e_a1 = e_rd ? 32'(int'(c.vs1) * 8 + k) : 32'd0;
      e_mv = (nb > 0) && (cyc >= 2) && (cyc <= nb + 1);
      e_ma = e_mv ? 32'(int'(c.vd) * 8 + j) : 32'd0;
      e_m0 = e_mv ? rfval(32'(int'(c.vs2) * 8 + j)) : 64'd0;
      e_m1 = e_mv ? rfval(32'(int'(c.vs1) * 8 + j)) : 64'd0;
      e_op = e_mv ? c.op : 3'd0;
      n_asserts++;
      if ({rf_rd_en, rf_rd_addr0, rf_rd_addr1} !== {e_rd, e_a0, e_a1}) begin
        n_fail++;
        $display("FAIL %s rd cyc%0d: got en=%b a0=%0d a1=%0d want en=%b a0=%0d a1=%0d",
                 tag, cyc, rf_rd_en, rf_rd_addr0, rf_rd_addr1, e_rd, e_a0, e_a1);
      end
      n_asserts++;
      if ({mop_valid, mop_addr, mop_opsel} !== {e_mv, e_ma, e_op}) begin
        n_fail++;
        $display("FAIL %s mop cyc%0d: got v=%b a=%0d op=%0d want v=%b a=%0d op=%0d",
                 tag, cyc, mop_valid, mop_addr, mop_opsel, e_mv, e_ma, e_op);
      end
      n_asserts++;
      if ({mop_m0, mop_m1} !== {e_m0, e_m1}) begin
        n_fail++;
        $display("FAIL %s data cyc%0d: got m0=%h m1=%h want m0=%h m1=%h",
                 tag, cyc, mop_m0, mop_m1, e_m0, e_m1);
      end
      n_asserts++;
      if ({busy, done, cmd_ready, err} !== {cyc <= dc, cyc == dc, cyc > dc, 1'b0}) begin
        n_fail++;
        $display("FAIL %s ctl cyc%0d: got busy=%b done=%b ready=%b err=%b want %b %b %b 0",
                 tag, cyc, busy, done, cmd_ready, err, cyc <= dc, cyc == dc, cyc > dc);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_asserts++;
    if ({cmd_ready, busy, done, err, rf_rd_en, mop_valid, rf_rd_addr0, rf_rd_addr1,
         mop_addr, mop_m0, mop_m1, mop_opsel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b busy=%b done=%b err=%b rd=%b mv=%b want all 0",
               cmd_ready, busy, done, err, rf_rd_en, mop_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    cmd_t c = '{vd: 5'd3, vs1: 5'd1, vs2: 5'd2, op: 3'd1, vl: 10'd130};
    @(posedge clk); #1 drive(c);
    run_cmd("vmand", c, 1'b0, c);
  endtask

  task automatic test_vl_zero();
    cmd_t c = '{vd: 5'd9, vs1: 5'd4, vs2: 5'd5, op: 3'd3, vl: 10'd0};
    @(posedge clk); #1 drive(c);
    run_cmd("vl0", c, 1'b0, c);
  endtask

  task automatic test_clamp();
    cmd_t c = '{vd: 5'd7, vs1: 5'd30, vs2: 5'd31, op: 3'd6, vl: 10'd600};
    @(posedge clk); #1 drive(c);
    run_cmd("clamp", c, 1'b0, c);
  endtask

  task automatic test_random();
    cmd_t c;
    for (int i = 0; i < 6; i++) begin
      c.vd  = 5'($urandom_range(0, 31));
      c.vs1 = 5'($urandom_range(0, 31));
      c.vs2 = 5'($urandom_range(0, 31));
      c.op  = 3'($urandom_range(0, 7));
      c.vl  = 10'($urandom_range(0, 700));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1 drive(c);
      run_cmd("rand", c, 1'b0, c);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t a = '{vd: 5'd10, vs1: 5'd11, vs2: 5'd12, op: 3'd2, vl: 10'd200};
    cmd_t b = '{vd: 5'd20, vs1: 5'd21, vs2: 5'd22, op: 3'd7, vl: 10'd64};
    @(posedge clk); #1 drive(a);
    run_cmd("b2b_first", a, 1'b1, b);
    run_cmd("b2b_second", b, 1'b0, b);
  endtask

  // A response landing in the same cycle as a beat must cancel, leaving nothing in flight.
  task automatic test_simultaneous();
    cmd_t c = '{vd: 5'd1, vs1: 5'd2, vs2: 5'd3, op: 3'd0, vl: 10'd64};
    resp_en = 1'b0;
    @(posedge clk); #1 drive(c);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 stray = 1'b1;
    @(negedge clk);
    n_asserts++;
    if (mop_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_beat: got mop_valid=%b want 1", mop_valid);
    end
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    n_asserts++;
    if ({done, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL simul_drain: got done=%b err=%b want 0 0", done, err);
    end
    @(negedge clk);
    n_asserts++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_done: got done=%b err=%b want 1 0", done, err);
    end
    resp_en = 1'b1;
    pulse_rst();
  endtask

  task automatic test_reset_mid();
    cmd_t c = '{vd: 5'd4, vs1: 5'd5, vs2: 5'd6, op: 3'd5, vl: 10'd256};
    @(posedge clk); #1 drive(c);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_asserts++;
    if ({cmd_ready, busy, done, err, rf_rd_en, mop_valid, rf_rd_addr0, rf_rd_addr1,
         mop_addr, mop_m0, mop_m1, mop_opsel} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ready=%b busy=%b done=%b err=%b rd=%b mv=%b want all 0",
               cmd_ready, busy, done, err, rf_rd_en, mop_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_asserts++;
    if ({cmd_ready, busy, err} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst_idle: got ready=%b busy=%b err=%b want 1 0 0", cmd_ready, busy, err);
    end
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_asserts++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL stray_err_sticky%0d: got err=%b want 1", i, err);
      end
    end
    pulse_rst();
    @(negedge clk);
    n_asserts++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got err=%b want 0", err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_vl_zero();
    test_clamp();
    test_random();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
